// File: rtl/key_filter_if.sv
// Key bus between the board-facing key pins and the key_filter outputs.
interface key_filter_if #(
    parameter int unsigned KEY_W = 2
);
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] key_level;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_long;

    modport master (output key, input key_level, input key_press, input key_long);
    modport slave  (input key, output key_level, output key_press, output key_long);
endinterface

// File: rtl/key_filter.sv
// Per-key synchroniser, debouncer and short/long press classifier for active-low keys.
// Optional macro KEY_LONG_EN compiles in long-press detection; undefined ties key_long to 0.
module key_filter #(
    parameter int unsigned CNT_MAX  = 1_000_000,
    parameter int unsigned LONG_MAX = 50_000_000,
    parameter int unsigned KEY_W    = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    key_filter_if.slave kif
);
    localparam int unsigned DEB_W = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_DOWN,
        HELD,
        DEB_UP
    } state_e;

    // Counter compares below assume at least two debounce samples and a non-zero hold time.
    if (CNT_MAX < 2 || LONG_MAX < 1) begin : g_bad_param
        $error("key_filter: CNT_MAX must be >= 2 and LONG_MAX >= 1");
    end

    for (genvar g = 0; g < int'(KEY_W); g++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        state_e           state_q;
        logic [DEB_W-1:0] deb_cnt_q;
        logic             level_q;
        logic             press_q;
        logic             long_q;
        logic             deb_last;
        logic             release_press;

        assign deb_last = (deb_cnt_q == DEB_W'(CNT_MAX - 1));

`ifdef KEY_LONG_EN
        localparam int unsigned HOLD_W = $clog2(LONG_MAX + 1);

        logic [HOLD_W-1:0] hold_cnt_q;
        logic              long_flag_q;
        logic              long_hit;

        // A long event firing on the release edge itself still suppresses the short press.
        assign long_hit      = (hold_cnt_q == HOLD_W'(LONG_MAX - 1)) && !long_flag_q;
        assign release_press = !(long_flag_q || long_hit);
`else
        assign release_press = 1'b1;
`endif

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                sync1_q     <= 1'b1;
                sync2_q     <= 1'b1;
                state_q     <= IDLE;
                deb_cnt_q   <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                long_q      <= 1'b0;
`ifdef KEY_LONG_EN
                hold_cnt_q  <= '0;
                long_flag_q <= 1'b0;
`endif
            end else begin
                sync1_q <= kif.key[g];
                sync2_q <= sync1_q;
                press_q <= 1'b0;
                long_q  <= 1'b0;

`ifdef KEY_LONG_EN
                // Hold time keeps running through the release debounce window.
                if (state_q == HELD || state_q == DEB_UP) begin
                    if (hold_cnt_q != HOLD_W'(LONG_MAX)) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                    if (long_hit) begin
                        long_q      <= 1'b1;
                        long_flag_q <= 1'b1;
                    end
                end
`endif

                case (state_q)
                    IDLE: begin
                        if (!sync2_q) begin
                            state_q   <= DEB_DOWN;
                            deb_cnt_q <= DEB_W'(1);
                        end
                    end
                    DEB_DOWN: begin
                        if (sync2_q) begin
                            state_q   <= IDLE;
                            deb_cnt_q <= '0;
                        end else if (deb_last) begin
                            state_q     <= HELD;
                            deb_cnt_q   <= '0;
                            level_q     <= 1'b1;
`ifdef KEY_LONG_EN
                            hold_cnt_q  <= '0;
                            long_flag_q <= 1'b0;
`endif
                        end else begin
                            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                        end
                    end
                    HELD: begin
                        if (sync2_q) begin
                            state_q   <= DEB_UP;
                            deb_cnt_q <= DEB_W'(1);
                        end
                    end
                    DEB_UP: begin
                        if (!sync2_q) begin
                            state_q   <= HELD;
                            deb_cnt_q <= '0;
                        end else if (deb_last) begin
                            state_q   <= IDLE;
                            deb_cnt_q <= '0;
                            level_q   <= 1'b0;
                            press_q   <= release_press;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign kif.key_level[g] = level_q;
        assign kif.key_press[g] = press_q;
        assign kif.key_long[g]  = long_q;
    end
endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with a run-length/hold-age reference model checked every cycle.
module tb_key_filter;
    localparam int unsigned CNT_MAX  = 25;
    localparam int unsigned LONG_MAX = 200;
    localparam int unsigned KEY_W    = 2;
`ifdef KEY_LONG_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    key_filter_if #(.KEY_W(KEY_W)) kif ();

    key_filter #(
        .CNT_MAX (CNT_MAX),
        .LONG_MAX(LONG_MAX),
        .KEY_W   (KEY_W)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .kif    (kif)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int n_press[2];
    int n_long[2];

    // Reference model: raw key seen two edges late; level flips after CNT_MAX disagreeing samples.
    logic [1:0] m_s1, m_s2, m_level, m_press, m_long;
    int         m_run[2];
    int         m_age[2];
    bit         m_long_done[2];

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_s1 = 2'b11; m_s2 = 2'b11;
            m_level = 2'b00; m_press = 2'b00; m_long = 2'b00;
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 0; m_age[k] = 0; m_long_done[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_press[k] = 1'b0;
                m_long[k]  = 1'b0;
                if (m_level[k]) begin
                    m_age[k]++;
                    if (LONG_EN && m_age[k] == int'(LONG_MAX) && !m_long_done[k]) begin
                        m_long[k] = 1'b1;
                        m_long_done[k] = 1'b1;
                    end
                end
                if ((!m_s2[k]) != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == int'(CNT_MAX)) begin
                        m_run[k] = 0;
                        if (m_level[k]) begin
                            m_level[k] = 1'b0;
                            m_press[k] = !m_long_done[k];
                        end else begin
                            m_level[k] = 1'b1;
                            m_age[k] = 0;
                            m_long_done[k] = 1'b0;
                        end
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = kif.key;
        end
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("model_level", kif.key_level, m_level);
            chk("model_press", kif.key_press, m_press);
            chk("model_long",  kif.key_long,  m_long);
            for (int k = 0; k < 2; k++) begin
                if (kif.key_press[k] === 1'b1) n_press[k]++;
                if (kif.key_long[k] === 1'b1)  n_long[k]++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic hold(input logic [1:0] v, input int n);
        kif.key = v;
        cyc(n);
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            n_press[k] = 0;
            n_long[k]  = 0;
        end
    endtask

    initial begin
        clr();
        kif.key = 2'b11;
        sys_rst = 1'b1;
        cyc(1);
        chk_en = 1'b1;

        // Reset held with keys released
        cyc(10);
        chk("rst_level", kif.key_level, 2'b00);
        chk("rst_press", kif.key_press, 2'b00);
        chk("rst_long",  kif.key_long,  2'b00);
        sys_rst = 1'b0;
        cyc(5);
        chk("post_rst_level", kif.key_level, 2'b00);

        // Short press on key0
        clr();
        hold(2'b10, 26);
        chk("short_level_e26", kif.key_level, 2'b00);
        cyc(1);
        chk("short_level_e27", kif.key_level, 2'b01);
        cyc(73);
        hold(2'b11, 26);
        chk("short_rel_e26", kif.key_level, 2'b01);
        cyc(1);
        chk("short_rel_e27_level", kif.key_level, 2'b00);
        chk("short_rel_e27_press", kif.key_press, 2'b01);
        cyc(10);
        chk_int("short_press_cnt0", n_press[0], 1);
        chk_int("short_press_cnt1", n_press[1], 0);
        chk_int("short_long_cnt", n_long[0] + n_long[1], 0);

        // Bounce on key0
        clr();
        hold(2'b10, 10);
        hold(2'b11, 3);
        hold(2'b10, 24);
        hold(2'b11, 2);
        hold(2'b10, 26);
        chk("bounce_e26", kif.key_level, 2'b00);
        cyc(1);
        chk("bounce_e27", kif.key_level, 2'b01);
        hold(2'b11, 40);
        chk_int("bounce_press_cnt", n_press[0], 1);

        // Long press on key1
        clr();
        hold(2'b01, 27);
        chk("long_level", kif.key_level, 2'b10);
        cyc(199);
        chk_int("long_early", n_long[1], 0);
        cyc(1);
        chk("long_pulse", kif.key_long, LONG_EN ? 2'b10 : 2'b00);
        cyc(173);
        hold(2'b11, 40);
        chk("long_rel_level", kif.key_level, 2'b00);
        chk_int("long_cnt", n_long[1], LONG_EN ? 1 : 0);
        chk_int("long_press_cnt", n_press[1], LONG_EN ? 0 : 1);

        // Simultaneous press on both keys
        clr();
        hold(2'b00, 27);
        chk("simul_level", kif.key_level, 2'b11);
        cyc(33);
        hold(2'b11, 27);
        chk("simul_press", kif.key_press, 2'b11);
        cyc(5);
        chk_int("simul_cnt0", n_press[0], 1);
        chk_int("simul_cnt1", n_press[1], 1);

        // Reset in the middle of a hold
        clr();
        hold(2'b10, 27);
        chk("midrst_level", kif.key_level, 2'b01);
        cyc(100);
        sys_rst = 1'b1;
        cyc(1);
        chk("midrst_out_level", kif.key_level, 2'b00);
        chk("midrst_out_press", kif.key_press, 2'b00);
        chk("midrst_out_long",  kif.key_long,  2'b00);
        cyc(4);
        sys_rst = 1'b0;
        cyc(26);
        chk("midrst_rerise_e26", kif.key_level, 2'b00);
        cyc(1);
        chk("midrst_rerise_e27", kif.key_level, 2'b01);
        chk_int("midrst_no_press", n_press[0] + n_press[1], 0);
        chk_int("midrst_no_long",  n_long[0] + n_long[1], 0);
        hold(2'b11, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
